// File: rtl/leg_uart_rx_if.sv
// Consumer-side bundle for leg_uart_rx. The receiver drives it through the
// master modport; the load path drives i_ready through the slave modport.
interface leg_uart_rx_if;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_busy;
    logic       o_frame_err;
    logic       o_overrun;

    modport master (
        output o_data,
        output o_valid,
        output o_busy,
        output o_frame_err,
        output o_overrun,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_busy,
        input  o_frame_err,
        input  o_overrun,
        output i_ready
    );
endinterface

// File: rtl/leg_uart_rx.sv
// 8N1 UART receiver with a small receive FIFO for the LEG SoC UART register.
//
// state | meaning
// BREAK | line seen low outside a frame; wait for idle-high before decoding
// IDLE  | line idle, looking for a start-bit falling level
// START | timing to the middle of the start bit to reject glitches
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | sampling the middle of the stop bit; push byte or flag framing error
module leg_uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          rx,
    leg_uart_rx_if.master bus
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {S_BREAK, S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic            r_rx_meta;
    logic            r_rx_s;
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            r_busy;
    logic            r_frame_err;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;
    logic            r_valid;
    logic            r_overrun;

    logic            w_cnt_last;
    logic            w_push;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;
    logic [CNTW-1:0] w_count_nxt;

    // Both stages reset high so a reset never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_push     = (r_state == S_STOP) && w_cnt_last && r_rx_s;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_BREAK;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_BREAK: begin
                    r_cnt <= '0;
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_busy  <= 1'b1;
                    end
                end
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_MID) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state <= S_DATA;
                            r_idx   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_cnt_last) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= r_rx_s;
                        r_idx          <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
                    if (w_cnt_last) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state     <= S_BREAK;
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_BREAK;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign w_full = (r_count == CNTW'(FIFO_DEPTH));
    assign w_pop  = r_valid && bus.i_ready;
    assign w_wr   = w_push && (!w_full || w_pop);

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_pop) begin
            w_count_nxt = r_count + CNTW'(1);
        end else if (!w_wr && w_pop) begin
            w_count_nxt = r_count - CNTW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count   <= w_count_nxt;
            r_valid   <= (w_count_nxt != '0);
            r_overrun <= w_push && w_full && !w_pop;
        end
    end

    // Head is gated so stale memory never shows while the FIFO is empty.
    assign bus.o_data      = r_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign bus.o_valid     = r_valid;
    assign bus.o_busy      = r_busy;
    assign bus.o_frame_err = r_frame_err;
    assign bus.o_overrun   = r_overrun;
endmodule

// File: tb/tb_leg_uart_rx.sv
// Scoreboard bench for leg_uart_rx: stimulus predicts each frame's outcome into
// a queue, an independent negedge monitor checks every pop and counts pulses.
module tb_leg_uart_rx;
    localparam int C = 8;
    localparam int D = 4;
    localparam int N = 2 + C / 2 + 9 * C;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    logic rx    = 1'b1;

    leg_uart_rx_if bus ();

    leg_uart_rx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int       errors = 0;
    int       checks = 0;
    bit [7:0] exp_q[$];
    int       exp_ferr = 0;
    int       exp_ovr  = 0;
    int       got_ferr = 0;
    int       got_ovr  = 0;
    bit       rdy_val  = 1'b0;
    bit       rdy_rand = 1'b0;
    bit       prev_valid = 1'b0;
    bit       busy_seen  = 1'b0;
    int       last_rise  = -1000;
    int       last_e0    = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_latency(input string name, input int e0);
        int d;
        d = last_rise - e0;
        checks++;
        if (d != N && d != N + 1) begin
            errors++;
            $display("FAIL %s: o_valid rose %0d edges after E0, expected %0d or %0d", name, d, N, N + 1);
        end
    endtask

    // Reference behaviour for one completed frame, evaluated just after the edge
    // where the stop bit is judged; pops seen by the monitor before that edge
    // have already left the queue.
    task automatic model_frame(input bit [7:0] b, input bit stop);
        if (!stop) exp_ferr++;
        else if (exp_q.size() < D) exp_q.push_back(b);
        else exp_ovr++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_frame(input bit [7:0] b, input bit stop, input bit pop_at_push);
        int e0;
        e0 = cyc + 1;
        last_e0 = e0;
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(C);
        end
        rx = stop;
        for (int i = 0; i < C; i++) begin
            tick(1);
            if (pop_at_push && cyc == e0 + N - 1) rdy_val = 1'b1;
            if (cyc == e0 + N) begin
                model_frame(b, stop);
                if (pop_at_push) rdy_val = 1'b0;
            end
        end
        rx = 1'b1;
    endtask

    task automatic phase_end(input string name);
        tick(4);
        check({name, "_frame_err_count"}, got_ferr, exp_ferr);
        check({name, "_overrun_count"}, got_ovr, exp_ovr);
        check({name, "_valid"}, bus.o_valid, exp_q.size() != 0);
    endtask

    task automatic pop_all(input string name);
        int n;
        n = 0;
        rdy_val = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            tick(1);
            n++;
        end
        tick(1);
        rdy_val = 1'b0;
        tick(3);
        check({name, "_drained_queue_left"}, exp_q.size(), 0);
        check({name, "_drained_valid"}, bus.o_valid, 0);
    endtask

    always @(posedge i_clk) begin
        #2;
        bus.i_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end

    always @(negedge i_clk) begin
        if (bus.o_frame_err) got_ferr++;
        if (bus.o_overrun) got_ovr++;
        if (bus.o_busy) busy_seen = 1'b1;
        if (bus.o_valid && !prev_valid) last_rise = cyc;
        prev_valid = bus.o_valid;
        if (!bus.o_valid) check("data_when_empty", bus.o_data, 0);
        if (bus.o_valid && bus.i_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no byte (cycle %0d)", bus.o_data, cyc);
            end else begin
                bit [7:0] e;
                e = exp_q.pop_front();
                if (bus.o_data != e) begin
                    errors++;
                    $display("FAIL pop_data: got 0x%0h, expected 0x%0h (cycle %0d)", bus.o_data, e, cyc);
                end
            end
        end
    end

    initial begin
        bus.i_ready = 1'b0;

        // Reset state
        tick(3);
        check("rst_data", bus.o_data, 0);
        check("rst_valid", bus.o_valid, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_frame_err", bus.o_frame_err, 0);
        check("rst_overrun", bus.o_overrun, 0);
        i_rst = 1'b1;
        tick(4);
        check("post_rst_busy", bus.o_busy, 0);
        check("post_rst_valid", bus.o_valid, 0);
        check("post_rst_data", bus.o_data, 0);

        // Single byte, consumer stalled
        last_rise = -1000;
        send_frame(8'hA5, 1'b1, 1'b0);
        tick(12);
        check_latency("a5_latency", last_e0);
        check("a5_valid_held", bus.o_valid, 1);
        check("a5_data", bus.o_data, 8'hA5);
        rdy_val = 1'b1;
        tick(1);
        rdy_val = 1'b0;
        tick(2);
        check("a5_valid_dropped", bus.o_valid, 0);
        check("a5_queue_empty", exp_q.size(), 0);

        // Glitch shorter than half a bit
        busy_seen = 1'b0;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(20);
        check("glitch_busy_seen", busy_seen, 1);
        check("glitch_busy_fell", bus.o_busy, 0);
        phase_end("glitch");

        // Framing error, then a good byte after idle
        send_frame(8'h3C, 1'b0, 1'b0);
        tick(2 * C);
        phase_end("ferr");
        send_frame(8'h5A, 1'b1, 1'b0);
        tick(4);
        check("ferr_next_data", bus.o_data, 8'h5A);
        phase_end("ferr_next");
        pop_all("ferr_next");

        // Overrun on the fifth byte, then wrap
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        check("ovr_head", bus.o_data, 8'h01);
        check("ovr_one_pulse", got_ovr, 1);
        phase_end("ovr");
        pop_all("ovr");
        for (int i = 6; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0);
        phase_end("wrap");
        pop_all("wrap");

        // Push and pop on the same edge while full
        for (int i = 0; i < 4; i++) send_frame(8'hB0 + 8'(i), 1'b1, 1'b0);
        send_frame(8'hEE, 1'b1, 1'b1);
        tick(2);
        check("simul_head", bus.o_data, 8'hB1);
        check("simul_model_count", exp_q.size(), 4);
        phase_end("simul");
        pop_all("simul");

        // Reset in the middle of DATA bit 3 of 8'hFF, released while rx low
        rx = 1'b0;
        tick(C);
        rx = 1'b1;
        tick(3 * C + C / 2);
        i_rst = 1'b0;
        rx = 1'b0;
        exp_q.delete();
        tick(3);
        check("midrst_valid", bus.o_valid, 0);
        check("midrst_busy", bus.o_busy, 0);
        i_rst = 1'b1;
        tick(12 * C);
        check("midrst_no_push", bus.o_valid, 0);
        rx = 1'b1;
        tick(2 * C);
        got_ferr = 0;
        exp_ferr = 0;
        last_rise = -1000;
        send_frame(8'h42, 1'b1, 1'b0);
        tick(4);
        check_latency("midrst_42_latency", last_e0);
        check("midrst_42_data", bus.o_data, 8'h42);
        phase_end("midrst");
        pop_all("midrst");

        // Randomized traffic with a random consumer
        rdy_rand = 1'b1;
        for (int f = 0; f < 16; f++) begin
            bit [7:0] b;
            bit       stop;
            b = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            send_frame(b, stop, 1'b0);
            if (!stop) tick(2 * C);
            else tick($urandom_range(0, 3));
        end
        rdy_rand = 1'b0;
        tick(2);
        phase_end("rand");
        pop_all("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
